mux_sweep_checker: RTL and testbench



---
 rtl/mux_sweep_pkg.sv | 17 +
 rtl/mux_sweep_settle_cnt.sv | 27 ++
 rtl/mux_sweep_checker.sv | 122 ++++++++++++
 tb/tb_mux_sweep_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sweep_pkg.sv
// Shared types for the 8:1 mux sweep checker.
// FSM encoding plus vector-index helpers.
package mux_sweep_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int NUM_VEC = 2 ** (SEL_W_DEF + 1);

  typedef logic [SEL_W_DEF:0] vec_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/mux_sweep_settle_cnt.sv
// Settle-time counter for the mux sweep checker.
// expire marks the last settle cycle of a vector.
module mux_sweep_settle_cnt #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign expire = en && (cnt == 4'(SETTLE_CYC - 1));

endmodule

// File: rtl/mux_sweep_checker.sv
// Sweeps every select code with two complementary data patterns
// and compares golden and post-route mux outputs.
module mux_sweep_checker
  import mux_sweep_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int SETTLE_CYC = 2,
  parameter logic [2**SEL_W-1:0] DATA_INIT = 8'hA5,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [SEL_W-1:0]   sel,
  output logic [2**SEL_W-1:0] d,
  input  logic               obs_golden,
  input  logic               obs_dut,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic               golden_err,
  output logic               first_fail_vld,
  output logic [SEL_W:0]     first_fail_vec
);

  state_t state;
  state_t state_nx;

  logic phase;
  logic go;
  logic last;
  logic expected;
  logic expire;
  logic cnt_clr;

  assign go = start && (state == IDLE || state == DONE);
  assign last = (&sel) && phase;
  assign expected = d[sel];
  assign cnt_clr = go || (state == SAMPLE);

  mux_sweep_settle_cnt #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (state == SETTLE),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = SETTLE;
      SETTLE:     if (expire) state_nx = SAMPLE;
      SAMPLE:     state_nx = last ? DONE : SETTLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel            <= '0;
      d              <= '0;
      phase          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch_cnt   <= '0;
      golden_err     <= 1'b0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if (go) begin
      sel            <= '0;
      d              <= DATA_INIT;
      phase          <= 1'b0;
      busy           <= 1'b1;
      done           <= 1'b0;
      mismatch_cnt   <= '0;
      golden_err     <= 1'b0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if (state == SAMPLE) begin
      if (obs_dut != obs_golden) begin
        if (mismatch_cnt != '1) begin
          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_vec <= {sel, phase};
        end
      end
      if (obs_golden != expected) begin
        golden_err <= 1'b1;
      end
      // final vector leaves sel/d on their last values
      unique case (1'b1)
        last: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        !phase: begin
          phase <= 1'b1;
          d     <= ~DATA_INIT;
        end
        default: begin
          phase <= 1'b0;
          d     <= DATA_INIT;
          sel   <= sel + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Scoreboard bench for mux_sweep_checker: an ideal/faulty mux
// environment, a sweep-level reference model and decoupled monitors.
module tb_mux_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] sel;
  logic [7:0] d;
  logic       obs_golden;
  logic       obs_dut;
  logic       busy;
  logic       done;
  logic [4:0] mismatch_cnt;
  logic       golden_err;
  logic       first_fail_vld;
  logic [3:0] first_fail_vec;

  always #5 clk = ~clk;

  mux_sweep_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .sel           (sel),
    .d             (d),
    .obs_golden    (obs_golden),
    .obs_dut       (obs_dut),
    .busy          (busy),
    .done          (done),
    .mismatch_cnt  (mismatch_cnt),
    .golden_err    (golden_err),
    .first_fail_vld(first_fail_vld),
    .first_fail_vec(first_fail_vec)
  );

  typedef struct {
    int mism;
    bit gerr;
    bit ffv;
    int ffvec;
  } res_t;

  res_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          gkind = 0;
  int          dkind = 0;
  logic [15:0] gmask = '0;
  logic [15:0] dmask = '0;
  bit          aborted = 0;

  // kind 0: ideal mux xor fault mask; 1: stuck at 0; 2: stuck at 1
  function automatic logic obs_f(int kind, logic [15:0] m, int v, logic e);
    case (kind)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return e ^ m[v];
    endcase
  endfunction

  always_comb begin
    int   vi;
    logic e;
    vi = int'(sel) * 2 + ((d == 8'h5A) ? 1 : 0);
    e = d[sel];
    obs_golden = obs_f(gkind, gmask, vi, e);
    obs_dut = obs_f(dkind, dmask, vi, e);
  end

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model();
    res_t       r;
    logic [7:0] pat;
    logic       e;
    logic       g;
    logic       u;
    r.mism = 0;
    r.gerr = 0;
    r.ffv = 0;
    r.ffvec = 0;
    for (int v = 0; v < 16; v++) begin
      pat = (v % 2 == 1) ? 8'h5A : 8'hA5;
      e = pat[v / 2];
      g = obs_f(gkind, gmask, v, e);
      u = obs_f(dkind, dmask, v, e);
      if (g != u) begin
        if (r.ffv == 0) begin
          r.ffv = 1;
          r.ffvec = v;
        end
        if (r.mism < 31) r.mism++;
      end
      if (g != e) r.gerr = 1;
    end
    return r;
  endfunction

  // result monitor: pops one expectation per done rising edge
  initial begin
    bit   prev_done = 0;
    res_t r;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          r = q.pop_front();
          check("mismatch_cnt", int'(mismatch_cnt), r.mism);
          check("golden_err", int'(golden_err), int'(r.gerr));
          check("first_fail_vld", int'(first_fail_vld), int'(r.ffv));
          check("first_fail_vec", int'(first_fail_vec), r.ffvec);
        end
      end
      prev_done = done;
    end
  end

  // sequence monitor: vector k/3 is presented on busy cycle k
  initial begin
    bit inb = 0;
    int k = 0;
    int vec;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!inb) begin
          inb = 1;
          k = 0;
        end
        vec = k / 3;
        if (k < 48) begin
          check("seq_sel", int'(sel), vec / 2);
          check("seq_d", int'(d), (vec % 2 == 1) ? 'h5A : 'hA5);
        end
        k++;
      end else if (inb) begin
        inb = 0;
        if (!aborted) check("sweep_len", k, 48);
        aborted = 0;
      end
    end
  end

  task automatic start_pulse(bit accept);
    @(negedge clk);
    start = 1'b1;
    if (accept) q.push_back(model());
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", int'(done), 1);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_sel"}, int'(sel), 0);
    check({tag, "_d"}, int'(d), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cnt"}, int'(mismatch_cnt), 0);
    check({tag, "_gerr"}, int'(golden_err), 0);
    check({tag, "_ffv"}, int'(first_fail_vld), 0);
    check({tag, "_ffvec"}, int'(first_fail_vec), 0);
  endtask

  task automatic run(int gk, logic [15:0] gm, int dk, logic [15:0] dm);
    gkind = gk;
    gmask = gm;
    dkind = dk;
    dmask = dm;
    start_pulse(1);
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run(0, '0, 0, '0);
    run(0, '0, 1, '0);
    run(0, '0, 0, 16'hFFFF);

    gkind = 2;
    dkind = 2;
    start_pulse(1);
    repeat (3) @(negedge clk);
    check("gerr_after_v0", int'(golden_err), 0);
    repeat (3) @(negedge clk);
    check("gerr_after_v1", int'(golden_err), 1);
    wait_done();

    gkind = 0;
    dkind = 0;
    start_pulse(1);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    aborted = 1;
    void'(q.pop_back());
    @(negedge clk);
    check_zero("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_done_low", int'(done), 0);
    run(0, '0, 0, '0);

    dkind = 1;
    start_pulse(1);
    repeat (9) @(negedge clk);
    start_pulse(0);
    wait_done();
    check("done_cnt8", int'(mismatch_cnt), 8);
    dkind = 0;
    start_pulse(1);
    check("restart_cnt", int'(mismatch_cnt), 0);
    check("restart_busy", int'(busy), 1);
    check("restart_done", int'(done), 0);
    wait_done();

    for (int i = 0; i < 8; i++) begin
      run((i % 4 == 3) ? int'($urandom_range(1, 2)) : 0,
          16'($urandom) & 16'($urandom),
          int'($urandom_range(0, 2)) % 2,
          16'($urandom));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
